// File: rtl/nabp_sched_pkg.sv
// Shared types for the filtered-RAM ping-pong scheduler: bank lifecycle
// states, the fill/process FSM state encodings and the default angle width.
package nabp_sched_pkg;

  localparam int ANGLE_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY      = 2'd0,
    BANK_FILLING    = 2'd1,
    BANK_FULL       = 2'd2,
    BANK_PROCESSING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_KICK = 2'd2,
    F_WAIT = 2'd3
  } fill_state_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_KICK = 2'd1,
    P_WAIT = 2'd2
  } proc_state_e;

endpackage

// File: rtl/nabp_bank_state.sv
// Lifecycle tracker for one filtered-RAM bank: remembers whether the bank is
// empty, being filled, full or being processed, plus the angle it holds.
module nabp_bank_state
  import nabp_sched_pkg::*;
#(
  parameter int ANGLE_WIDTH = ANGLE_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_fill_start,
  input  logic [ANGLE_WIDTH-1:0] i_angle,
  input  logic                   i_fill_done,
  input  logic                   i_proc_start,
  input  logic                   i_proc_done,
  output bank_state_e            o_state,
  output logic [ANGLE_WIDTH-1:0] o_angle
);

  bank_state_e            r_state;
  logic [ANGLE_WIDTH-1:0] r_angle;

  // Each event only fires from the one state that precedes it, so at most one
  // is ever active for a given bank; the if-chain order is therefore free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BANK_EMPTY;
      r_angle <= '0;
    end else if (i_fill_start) begin
      r_state <= BANK_FILLING;
      r_angle <= i_angle;
    end else if (i_fill_done) begin
      r_state <= BANK_FULL;
    end else if (i_proc_start) begin
      r_state <= BANK_PROCESSING;
    end else if (i_proc_done) begin
      r_state <= BANK_EMPTY;
    end
  end

  assign o_state = r_state;
  assign o_angle = r_angle;

endmodule

// File: rtl/nabp_filtered_ram_swap_scheduler.sv
// Ping-pong scheduler for two filtered-RAM banks: one side requests angles
// from the host and fills a bank while the other side processes the opposite
// bank. Banks are used strictly alternately so angles finish in host order.
module nabp_filtered_ram_swap_scheduler
  import nabp_sched_pkg::*;
#(
  parameter int ANGLE_WIDTH = ANGLE_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hs_has_next_angle,
  output logic                   hs_next_angle,
  input  logic                   hs_next_angle_ack,
  input  logic [ANGLE_WIDTH-1:0] hs_angle,
  output logic                   fl_kick,
  output logic                   fl_bank,
  output logic [ANGLE_WIDTH-1:0] fl_angle,
  input  logic                   fl_done,
  output logic                   pr_kick,
  output logic                   pr_bank,
  output logic [ANGLE_WIDTH-1:0] pr_angle,
  input  logic                   pr_done,
  output logic                   sc_done
);

  fill_state_e            r_fill_state;
  fill_state_e            w_fill_next;
  proc_state_e            r_proc_state;
  proc_state_e            w_proc_next;
  logic                   r_fill_ptr;
  logic                   r_proc_ptr;
  bank_state_e            w_bank_state [2];
  logic [ANGLE_WIDTH-1:0] w_bank_angle [2];

  logic w_fill_start;
  logic w_fill_done;
  logic w_proc_start;
  logic w_proc_done;

  // Bank events are qualified by FSM state so stray done pulses do nothing.
  assign w_fill_start = (r_fill_state == F_REQ) && hs_next_angle_ack;
  assign w_fill_done  = (r_fill_state == F_WAIT) && fl_done;
  assign w_proc_start = (r_proc_state == P_IDLE) &&
                        (w_bank_state[r_proc_ptr] == BANK_FULL);
  assign w_proc_done  = (r_proc_state == P_WAIT) && pr_done;

  nabp_bank_state #(.ANGLE_WIDTH(ANGLE_WIDTH)) u_bank0 (
    .clk          (clk),
    .reset        (reset),
    .i_fill_start (w_fill_start && (r_fill_ptr == 1'b0)),
    .i_angle      (hs_angle),
    .i_fill_done  (w_fill_done && (r_fill_ptr == 1'b0)),
    .i_proc_start (w_proc_start && (r_proc_ptr == 1'b0)),
    .i_proc_done  (w_proc_done && (r_proc_ptr == 1'b0)),
    .o_state      (w_bank_state[0]),
    .o_angle      (w_bank_angle[0])
  );

  nabp_bank_state #(.ANGLE_WIDTH(ANGLE_WIDTH)) u_bank1 (
    .clk          (clk),
    .reset        (reset),
    .i_fill_start (w_fill_start && (r_fill_ptr == 1'b1)),
    .i_angle      (hs_angle),
    .i_fill_done  (w_fill_done && (r_fill_ptr == 1'b1)),
    .i_proc_start (w_proc_start && (r_proc_ptr == 1'b1)),
    .i_proc_done  (w_proc_done && (r_proc_ptr == 1'b1)),
    .o_state      (w_bank_state[1]),
    .o_angle      (w_bank_angle[1])
  );

  // Fill side state and pointer; the pointer advances only on a real fill
  // completion so banks are always filled in 0,1,0,1 order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_state <= F_IDLE;
      r_fill_ptr   <= 1'b0;
    end else begin
      r_fill_state <= w_fill_next;
      if (w_fill_done) r_fill_ptr <= ~r_fill_ptr;
    end
  end

  // Fill side next state: wait for an empty target bank and a host angle,
  // hold the request until ack, kick the filler, then wait for its done.
  always_comb begin
    w_fill_next = r_fill_state;
    case (r_fill_state)
      F_IDLE: if ((w_bank_state[r_fill_ptr] == BANK_EMPTY) && hs_has_next_angle)
                w_fill_next = F_REQ;
      F_REQ:  if (hs_next_angle_ack) w_fill_next = F_KICK;
      F_KICK: w_fill_next = F_WAIT;
      F_WAIT: if (fl_done) w_fill_next = F_IDLE;
      default: w_fill_next = F_IDLE;
    endcase
  end

  // Process side state and pointer, mirroring the fill side ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_proc_state <= P_IDLE;
      r_proc_ptr   <= 1'b0;
    end else begin
      r_proc_state <= w_proc_next;
      if (w_proc_done) r_proc_ptr <= ~r_proc_ptr;
    end
  end

  // Process side next state: start as soon as the target bank reads FULL
  // from its register, then wait for the processor to finish.
  always_comb begin
    w_proc_next = r_proc_state;
    case (r_proc_state)
      P_IDLE: if (w_bank_state[r_proc_ptr] == BANK_FULL) w_proc_next = P_KICK;
      P_KICK: w_proc_next = P_WAIT;
      P_WAIT: if (pr_done) w_proc_next = P_IDLE;
      default: w_proc_next = P_IDLE;
    endcase
  end

  assign hs_next_angle = (r_fill_state == F_REQ);
  assign fl_kick       = (r_fill_state == F_KICK);
  assign pr_kick       = (r_proc_state == P_KICK);
  assign fl_bank       = r_fill_ptr;
  assign pr_bank       = r_proc_ptr;
  assign fl_angle      = w_bank_angle[r_fill_ptr];
  assign pr_angle      = w_bank_angle[r_proc_ptr];
  assign sc_done       = !hs_has_next_angle &&
                         (w_bank_state[0] == BANK_EMPTY) &&
                         (w_bank_state[1] == BANK_EMPTY) &&
                         (r_fill_state == F_IDLE) &&
                         (r_proc_state == P_IDLE);

endmodule

// File: tb/tb_nabp_filtered_ram_swap_scheduler.sv
// Self-checking bench for the ping-pong bank scheduler. Host, filler and
// processor agents react to the DUT; expected event cycles come from the
// scheduling rules written as max() of dependency times per angle.
module tb_nabp_filtered_ram_swap_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsHasNextAngle;
  logic       hsNextAngle;
  logic       hsNextAngleAck;
  logic [7:0] hsAngle;
  logic       flKick;
  logic       flBank;
  logic [7:0] flAngle;
  logic       flDone;
  logic       prKick;
  logic       prBank;
  logic [7:0] prAngle;
  logic       prDone;
  logic       scDone;

  int errorCount = 0;
  int checkCount = 0;
  int cyc = 0;
  logic [7:0] angles [16];

  nabp_filtered_ram_swap_scheduler #(.ANGLE_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .hs_has_next_angle (hsHasNextAngle),
    .hs_next_angle     (hsNextAngle),
    .hs_next_angle_ack (hsNextAngleAck),
    .hs_angle          (hsAngle),
    .fl_kick           (flKick),
    .fl_bank           (flBank),
    .fl_angle          (flAngle),
    .fl_done           (flDone),
    .pr_kick           (prKick),
    .pr_bank           (prBank),
    .pr_angle          (prAngle),
    .pr_done           (prDone),
    .sc_done           (scDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic hasNext, input logic ack,
                               input logic [7:0] angle, input logic fDone,
                               input logic pDone);
    hsHasNextAngle = hasNext;
    hsNextAngleAck = ack;
    hsAngle        = angle;
    flDone         = fDone;
    prDone         = pDone;
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs n angles through the scheduler. Latency arguments < 0 pick random
  // values. Angle k may be requested two cycles after fill k-1 finished and
  // two cycles after processing of k-2 (same bank) finished; processing of
  // angle j kicks two cycles after its fill and after processing of j-1.
  task automatic runStream(input int n, input int hostLat, input int fillLat,
                           input int procLat);
    int flDoneC [16];
    int prDoneC [16];
    int k = 0, fk = 0, fd = 0, pk = 0, pd = 0;
    int hostWait = -1, fillCnt = 0, procCnt = 0;
    int startC, lastAck = -100, reqAt, kickAt;
    logic expHs, expPk, ack, fDone, pDone, hasNext, expSc;
    logic [7:0] ackAngle;
    for (int i = 0; i < 16; i++) begin
      flDoneC[i] = 0;
      prDoneC[i] = 0;
    end
    applyReset();
    startC = cyc;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int b = 0; b < 3000; b++) begin
      if (pd == n && cyc >= prDoneC[n-1] + 2) break;
      tick();
      expHs = 1'b0;
      if (k < n) begin
        if (k == 0) expHs = (cyc >= startC + 1);
        else if (fd >= k) begin
          reqAt = flDoneC[k-1] + 2;
          if (k >= 2) begin
            if (pd >= k - 1) begin
              if (prDoneC[k-2] + 2 > reqAt) reqAt = prDoneC[k-2] + 2;
            end else reqAt = 1 << 30;
          end
          expHs = (cyc >= reqAt);
        end
      end
      expPk = 1'b0;
      if (pk < n && fd > pk && (pk == 0 || pd >= pk)) begin
        kickAt = flDoneC[pk] + 2;
        if (pk > 0 && prDoneC[pk-1] + 2 > kickAt) kickAt = prDoneC[pk-1] + 2;
        expPk = (cyc == kickAt);
      end
      checkOutput("hs_next_angle", hsNextAngle, expHs);
      checkOutput("fl_kick", flKick, (cyc == lastAck + 1));
      checkOutput("pr_kick", prKick, expPk);

      fDone = 1'b0;
      if (fillCnt > 0) begin
        fillCnt--;
        if (fillCnt == 0) fDone = 1'b1;
      end
      pDone = 1'b0;
      if (procCnt > 0) begin
        procCnt--;
        if (procCnt == 0) pDone = 1'b1;
      end
      if (flKick && fillCnt == 0 && !fDone) begin
        if (fk < n) begin
          checkOutput("fl_angle", flAngle, angles[fk]);
          checkOutput("fl_bank", flBank, fk % 2);
        end
        fk++;
        fillCnt = (fillLat < 0) ? int'($urandom_range(1, 6)) : fillLat;
      end
      if (prKick && procCnt == 0 && !pDone) begin
        if (pk < n) begin
          checkOutput("pr_angle", prAngle, angles[pk]);
          checkOutput("pr_bank", prBank, pk % 2);
        end
        pk++;
        procCnt = (procLat < 0) ? int'($urandom_range(1, 8)) : procLat;
      end
      if (fk > fd && pk > pd) checkOutput("bank_overlap", (flBank == prBank), 1'b0);

      ack = 1'b0;
      ackAngle = 8'h00;
      if (hsNextAngle && k < n) begin
        if (hostWait < 0) hostWait = (hostLat < 0) ? int'($urandom_range(0, 3)) : hostLat;
        if (hostWait == 0) begin
          ack = 1'b1;
          ackAngle = angles[k];
          lastAck = cyc;
          k++;
          hostWait = -1;
        end else hostWait--;
      end
      if (fDone && fd < 16) begin
        flDoneC[fd] = cyc;
        fd++;
      end
      if (pDone && pd < 16) begin
        prDoneC[pd] = cyc;
        pd++;
      end
      hasNext = (k < n);
      applyStimulus(hasNext, ack, ackAngle, fDone, pDone);
      #1;
      expSc = !hasNext && (pd == n) && (cyc >= prDoneC[n-1] + 1);
      checkOutput("sc_done", scDone, expSc);
    end
    checkOutput("stream_complete", pd, n);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("sc_done_drop", scDone, 1'b0);
  endtask

  // Drives both FSMs into their wait states, resets, then shows that late
  // done pulses leave the banks empty.
  task automatic resetDuringWaits();
    applyReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("rst_seq_hs", hsNextAngle, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    checkOutput("rst_seq_flkick", flKick, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("rst_seq_prkick", prKick, 1'b1);
    checkOutput("rst_seq_hs2", hsNextAngle, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
    tick();
    checkOutput("rst_seq_flkick2", flKick, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_hs", hsNextAngle, 1'b0);
    checkOutput("rst_flkick", flKick, 1'b0);
    checkOutput("rst_prkick", prKick, 1'b0);
    checkOutput("rst_flangle", flAngle, 8'h00);
    checkOutput("rst_prangle", prAngle, 8'h00);
    checkOutput("rst_flbank", flBank, 1'b0);
    checkOutput("rst_prbank", prBank, 1'b0);
    checkOutput("rst_scdone", scDone, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("ign_done_sc", scDone, 1'b1);
    checkOutput("ign_done_prkick", prKick, 1'b0);
    tick();
    checkOutput("ign_done_prkick2", prKick, 1'b0);
    checkOutput("ign_done_sc2", scDone, 1'b1);
    checkOutput("ign_done_hs", hsNextAngle, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    applyReset();
    checkOutput("reset_hs", hsNextAngle, 1'b0);
    checkOutput("reset_flkick", flKick, 1'b0);
    checkOutput("reset_prkick", prKick, 1'b0);
    checkOutput("reset_flbank", flBank, 1'b0);
    checkOutput("reset_prbank", prBank, 1'b0);
    checkOutput("reset_flangle", flAngle, 8'h00);
    checkOutput("reset_scdone", scDone, 1'b1);

    angles[0] = 8'h05;
    runStream(1, 3, 4, 4);

    angles[0] = 8'h01;
    angles[1] = 8'h02;
    angles[2] = 8'h03;
    runStream(3, 0, 10, 20);

    for (int i = 0; i < 16; i++) angles[i] = 8'($urandom_range(0, 255));
    runStream(4, 0, 1, 15);
    runStream(6, 0, 4, 5);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) angles[i] = 8'($urandom_range(0, 255));
      runStream(12, -1, -1, -1);
    end

    resetDuringWaits();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
